// File: rtl/regfile_wb_pkg.sv
// Purpose : shared widths and the write-back entry type for the register-file write front end.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package regfile_wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int POS_W  = 4;
  localparam int NREG   = 1 << ADDR_W;

  // One pending register-file write: destination, value and is_pos tag.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [POS_W-1:0]  pos;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Purpose : circular buffer for long-latency write-back entries.
// Latency : an entry pushed at edge N is visible on head_o after that edge.
// Backpr. : full_o is registered state only; the caller must not push when full.
// Ports   : clk_i/reset_n (sync, active-low), push_i/push_dat_i, pop_i,
//           head_o, full_o, empty_o, count_o (0..DEPTH).
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             push_i,
  input  wb_entry_t        push_dat_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only read while count_q > 0.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose : merges ALU and long-latency results onto the single register-file write port; pending-write scoreboard.
// Latency : ALU cycle N -> RegWrite_o cycle N+1; long-latency transfer cycle N -> RegWrite_o cycle N+2 if no ALU traffic.
// Backpr. : ALU has none and always wins; lu_ready_o = !full (no pop-to-push pass-through), 0 during reset.
// Ports   : alu_* (ALU result), lu_* (valid/ready long-latency result), issue_*/RSaddr_i/RTaddr_i/DSTaddr_i
//           (scoreboard set and hazard query), hazard_o/busy_o, RDaddr_o/RDdata_o/RegWrite_o/is_pos_o (to regfile).
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              alu_valid_i,
  input  logic [ADDR_W-1:0] alu_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [POS_W-1:0]  alu_pos_i,
  input  logic              lu_valid_i,
  output logic              lu_ready_o,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  input  logic [POS_W-1:0]  lu_pos_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  input  logic [ADDR_W-1:0] DSTaddr_i,
  output logic              hazard_o,
  output logic [NREG-1:0]   busy_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  output logic              RegWrite_o,
  output logic [POS_W-1:0]  is_pos_o
);

  wb_entry_t lu_entry;
  wb_entry_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;
  logic [$clog2(DEPTH+1)-1:0] fifo_count_unused;  // occupancy, kept for debug probing

  wb_entry_t       wb_q, wb_d;
  logic            we_q, we_d;
  logic [NREG-1:0] busy_q, busy_d;

  assign lu_entry.addr = lu_addr_i;
  assign lu_entry.data = lu_data_i;
  assign lu_entry.pos  = lu_pos_i;

  assign lu_ready_o = reset_n & ~fifo_full;
  assign fifo_push  = lu_valid_i & lu_ready_o;
  // The FIFO head only drains in cycles the ALU leaves the port free.
  assign fifo_pop   = ~alu_valid_i & ~fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .push_i     (fifo_push),
    .push_dat_i (lu_entry),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count_unused)
  );

  // Write-port selection; payload holds when nothing is selected.
  always_comb begin
    wb_d = wb_q;
    we_d = 1'b0;
    if (alu_valid_i) begin
      wb_d.addr = alu_addr_i;
      wb_d.data = alu_data_i;
      wb_d.pos  = alu_pos_i;
      we_d      = 1'b1;
    end else if (fifo_pop) begin
      wb_d = fifo_head;
      we_d = 1'b1;
    end
  end

  // Clear first, then set, so a same-edge issue to the retiring register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) begin
      busy_d[fifo_head.addr] = 1'b0;
    end
    if (issue_i) begin
      busy_d[issue_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      wb_q   <= '0;
      we_q   <= 1'b0;
      busy_q <= '0;
    end else begin
      wb_q   <= wb_d;
      we_q   <= we_d;
      busy_q <= busy_d;
    end
  end

  assign hazard_o   = busy_q[RSaddr_i] | busy_q[RTaddr_i] | busy_q[DSTaddr_i];
  assign busy_o     = busy_q;
  assign RDaddr_o   = wb_q.addr;
  assign RDdata_o   = wb_q.data;
  assign is_pos_o   = wb_q.pos;
  assign RegWrite_o = we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic [3:0]  alu_pos;
  logic        lu_valid;
  logic        lu_ready_o;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [3:0]  lu_pos;
  logic        issue;
  logic [4:0]  issue_addr;
  logic [4:0]  rs_addr, rt_addr, dst_addr;
  logic        hazard_o;
  logic [31:0] busy_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;
  logic [3:0]  is_pos_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .reset_n      (reset_n),
    .alu_valid_i  (alu_valid),
    .alu_addr_i   (alu_addr),
    .alu_data_i   (alu_data),
    .alu_pos_i    (alu_pos),
    .lu_valid_i   (lu_valid),
    .lu_ready_o   (lu_ready_o),
    .lu_addr_i    (lu_addr),
    .lu_data_i    (lu_data),
    .lu_pos_i     (lu_pos),
    .issue_i      (issue),
    .issue_addr_i (issue_addr),
    .RSaddr_i     (rs_addr),
    .RTaddr_i     (rt_addr),
    .DSTaddr_i    (dst_addr),
    .hazard_o     (hazard_o),
    .busy_o       (busy_o),
    .RDaddr_o     (RDaddr_o),
    .RDdata_o     (RDdata_o),
    .RegWrite_o   (RegWrite_o),
    .is_pos_o     (is_pos_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  p;
  } ent_t;

  ent_t        mq[$];
  logic        m_busy [32];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_pos;
  bit          mvalid = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_we = 0; m_addr = '0; m_data = '0; m_pos = '0;
      mvalid = 1;
    end else if (mvalid) begin
      bit accept;
      ent_t e;
      accept = lu_valid && (mq.size() < DEPTH);
      if (alu_valid) begin
        m_we = 1; m_addr = alu_addr; m_data = alu_data; m_pos = alu_pos;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1; m_addr = e.a; m_data = e.d; m_pos = e.p;
        m_busy[e.a] = 1'b0;
      end else begin
        m_we = 0;
      end
      if (issue) m_busy[issue_addr] = 1'b1;
      if (accept) begin
        e.a = lu_addr; e.d = lu_data; e.p = lu_pos;
        mq.push_back(e);
      end
    end
  end

  // Single compare process against the model on every falling edge.
  always @(negedge clk) begin
    if (mvalid) begin
      logic [31:0] mb;
      for (int r = 0; r < 32; r++) mb[r] = m_busy[r];
      chk("we", RegWrite_o, m_we);
      chk("addr", RDaddr_o, m_addr);
      chk("data", RDdata_o, m_data);
      chk("pos", is_pos_o, m_pos);
      chk("ready", lu_ready_o, reset_n && (mq.size() < DEPTH));
      chk("busy", busy_o, mb);
      chk("hazard", hazard_o, mb[rs_addr] | mb[rt_addr] | mb[dst_addr]);
    end
  end

  logic [31:0] wrap_log[$];
  always @(negedge clk) begin
    if (RegWrite_o === 1'b1 && RDaddr_o === 5'd30) wrap_log.push_back(RDdata_o);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit acc;
    int budget;
    reset_n = 0; alu_valid = 0; alu_addr = 0; alu_data = 0; alu_pos = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0; lu_pos = 0;
    issue = 0; issue_addr = 0; rs_addr = 0; rt_addr = 0; dst_addr = 0;
    cyc(); cyc();
    chk("rst_we", RegWrite_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", lu_ready_o, 0);
    reset_n = 1;
    cyc();
    chk("rel_ready", lu_ready_o, 1);

    // ALU only
    alu_valid = 1; alu_addr = 5; alu_data = 32'h1234_5678; alu_pos = 4'h3;
    cyc();
    alu_valid = 0;
    chk("alu_we", RegWrite_o, 1);
    chk("alu_addr", RDaddr_o, 5);
    chk("alu_data", RDdata_o, 32'h1234_5678);
    chk("alu_pos", is_pos_o, 3);
    cyc();
    chk("alu_we_off", RegWrite_o, 0);

    // Long-latency path
    issue = 1; issue_addr = 7; rs_addr = 7;
    cyc();
    issue = 0;
    chk("ll_busy7", busy_o[7], 1);
    chk("ll_hazard", hazard_o, 1);
    lu_valid = 1; lu_addr = 7; lu_data = 32'hff_ee_11_00; lu_pos = 4'h1;
    cyc();
    lu_valid = 0;
    chk("ll_we_n1", RegWrite_o, 0);
    cyc();
    chk("ll_we", RegWrite_o, 1);
    chk("ll_addr", RDaddr_o, 7);
    chk("ll_data", RDdata_o, 32'hff_ee_11_00);
    chk("ll_busy7_clr", busy_o[7], 0);
    chk("ll_hazard_clr", hazard_o, 0);
    rs_addr = 0;
    cyc();

    // Contention: ALU for 3 cycles, two long-latency pushes
    alu_valid = 1; alu_addr = 10; alu_data = 32'hA0;
    lu_valid = 1; lu_addr = 20; lu_data = 32'hB0;
    cyc();
    chk("ct_addr1", RDaddr_o, 10);
    alu_addr = 11; alu_data = 32'hA1; lu_addr = 21; lu_data = 32'hB1;
    cyc();
    chk("ct_addr2", RDaddr_o, 11);
    chk("ct_full", lu_ready_o, 0);
    lu_valid = 0; alu_addr = 12; alu_data = 32'hA2;
    cyc();
    chk("ct_addr3", RDaddr_o, 12);
    chk("ct_full2", lu_ready_o, 0);
    alu_valid = 0;
    cyc();
    chk("ct_addr4", RDaddr_o, 20);
    chk("ct_data4", RDdata_o, 32'hB0);
    cyc();
    chk("ct_addr5", RDaddr_o, 21);
    chk("ct_data5", RDdata_o, 32'hB1);
    cyc();
    chk("ct_idle", RegWrite_o, 0);

    // Full / wrap: six entries with intermittent ALU blocking
    for (int i = 0; i < 6; i++) begin
      lu_valid = 1; lu_addr = 30; lu_data = 32'(100 + i); lu_pos = 4'(i);
      alu_valid = (i % 2 == 0); alu_addr = 31; alu_data = 32'(i);
      acc = 0; budget = 0;
      while (!acc && budget < 20) begin
        acc = lu_ready_o;
        cyc();
        budget++;
      end
      chk("wrap_accept", acc, 1);
    end
    lu_valid = 0; alu_valid = 0;
    repeat (4) cyc();
    chk("wrap_count", wrap_log.size(), 6);
    for (int i = 0; i < 6 && i < wrap_log.size(); i++)
      chk("wrap_order", wrap_log[i], 32'(100 + i));

    // Same-edge set/clear on register 9
    issue = 1; issue_addr = 9;
    cyc();
    issue = 0; lu_valid = 1; lu_addr = 9; lu_data = 32'h99; lu_pos = 4'h9;
    cyc();
    lu_valid = 0; issue = 1; issue_addr = 9;
    cyc();
    issue = 0;
    chk("se_we", RegWrite_o, 1);
    chk("se_addr", RDaddr_o, 9);
    chk("se_busy9", busy_o[9], 1);
    cyc();
    chk("se_busy9_hold", busy_o[9], 1);

    // Reset mid-operation
    issue = 1; issue_addr = 3;
    alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
    cyc();
    issue = 0; lu_valid = 1; lu_addr = 3; lu_data = 32'hdead_0001;
    cyc();
    lu_data = 32'hdead_0002;
    cyc();
    chk("mr_full", lu_ready_o, 0);
    chk("mr_busy3", busy_o[3], 1);
    reset_n = 0; lu_valid = 0; alu_valid = 0;
    cyc();
    chk("mr_we", RegWrite_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_ready_low", lu_ready_o, 0);
    reset_n = 1;
    cyc();
    chk("mr_ready", lu_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      chk("mr_no_write", RegWrite_o, 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
